// File: rtl/fifo_read_drain.sv
// FIFO read-side drain: pulls words from a FIFO with r_en and streams them out
// on a valid/ready interface through a 2-entry skid buffer, with underflow halt.
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  read_error,
  output logic                  r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           rd_count,
  output logic                  halted,
  input  logic                  clear_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HALT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic [2:0]            pending;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALT);
    end
  end

  always_comb begin
    state_next = state;
    if (read_error) begin
      state_next = HALT;
    end else begin
      case (state)
        IDLE:    if (enable)    state_next = ACTIVE;
        ACTIVE:  if (!enable)   state_next = IDLE;
        HALT:    if (clear_err) state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  // A read is only issued when its word is guaranteed a free slot after this
  // cycle's pop, so the buffer can never be pushed while full.
  always_comb begin
    m_valid = (occ != 2'd0);
    m_data  = head;
    pop     = m_valid & m_ready;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    r_en    = ~rrst & (state == ACTIVE) & ~empty & (pending < 3'd2);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight <= 1'b0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      rd_count <= '0;
    end else begin
      inflight <= r_en;
      if (pop) begin
        rd_count <= rd_count + 16'd1;
      end
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= data_out;
          end else begin
            tail <= data_out;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= data_out;
          end else begin
            head <= tail;
            tail <= data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
